byte_deframer: RTL and testbench
================================

BYTE_DEFRAMER -- requirements
Module: byte_deframer

Interface
REQ-001 Parameter SYNC_WORD, default 8'hA5: frame-start pattern hunted in the serial stream.
REQ-002 Parameter FRAME_LEN, default 10: payload bytes per frame, legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port bit_in, input, 1: serial data bit, MSB of each byte first.
REQ-006 Port bit_valid, input, 1: bit_in is sampled only in cycles where this is high.
REQ-007 Port data_out, output, 8: last assembled payload byte; write data for the downstream sink.
REQ-008 Port byte_valid, output, 1: one-cycle pulse when data_out holds a new byte.
REQ-009 Port start_sink, output, 1: one-cycle pulse on sync detection; starts the downstream sink.
REQ-010 Port frame_done, output, 1: one-cycle pulse after the last payload byte of a frame.
REQ-011 Port sync_lock, output, 1: high while in state PAYLOAD.
REQ-012 Port parity_err, output, 1: one-cycle pulse on a payload parity mismatch.

Function
REQ-013 FSM states: HUNT, PAYLOAD, DONE; the FSM shall enter HUNT at reset.
REQ-014 HUNT: the FSM shall shift each valid bit into an 8-bit window, oldest bit at bit 7.
REQ-015 HUNT: when the window including the current valid bit equals SYNC_WORD, the FSM shall go to PAYLOAD and pulse start_sink in the next cycle.
REQ-016 PAYLOAD: the block shall assemble 8 valid bits, MSB first; gaps in bit_valid shall stall assembly with no loss.
REQ-017 On the 8th payload bit, data_out shall update and byte_valid shall pulse in the next cycle, giving 1-cycle latency from the last bit.
REQ-018 An 8-bit byte counter shall increment per delivered byte; at count == FRAME_LEN the FSM shall go to DONE in that same cycle.
REQ-019 DONE: the FSM shall pulse frame_done for one cycle, clear the window, counter and bit index, and return to HUNT in the next cycle.
REQ-020 In DONE, a bit_valid bit shall be discarded and shall not enter the HUNT window.
REQ-021 Sync patterns inside a payload shall be treated as data; no resynchronisation mid-frame.
REQ-022 byte_valid and frame_done shall never be high in the same cycle; frame_done follows the last byte_valid by exactly 1 cycle.
REQ-023 data_out shall hold its value between byte_valid pulses.

Reset
REQ-024 Reset low shall immediately force HUNT and clear the window, counter, bit index, data_out=8'h00, byte_valid=0, start_sink=0, frame_done=0, sync_lock=0, parity_err=0.
REQ-025 Reset mid-frame shall abandon the partial byte and emit no frame_done; the next frame requires a fresh SYNC_WORD.

Configuration
REQ-026 With macro BYTE_DEFRAMER_PARITY_EN defined, each payload byte shall be followed by one even-parity bit, and byte_valid shall fire after the parity bit; a mismatch shall pulse parity_err together with byte_valid, and the byte shall still be delivered and counted.
REQ-027 Without BYTE_DEFRAMER_PARITY_EN, bytes shall be 8 bits with no parity bit, and parity_err shall be tied to 0.

Structure
REQ-028 Package deframer_pkg shall hold the state enum (HUNT/PAYLOAD/DONE) and default constants SYNC_WORD_DEF=8'hA5 and FRAME_LEN_DEF=10.
REQ-029 Sub-module sync_detector shall contain the 8-bit shift window and comparator, and output a one-cycle match flag; the FSM, byte assembly and counter shall stay in byte_deframer.

Verification
REQ-030 Reset low for 3 cycles, then release -> all outputs 0, sync_lock=0, data_out=8'h00.
REQ-031 Stream 0,1 noise bits then A5, then 10 bytes 8'h00..8'h09 with bit_valid continuously high -> one start_sink pulse, 10 byte_valid pulses with data_out 00..09, then frame_done one cycle after the last, with sync_lock falling.
REQ-032 Same frame with bit_valid low on every other cycle -> identical byte sequence and count, with no extra or missing pulses.
REQ-033 Payload byte 8'hA5 inside a frame -> delivered as data, no second start_sink, frame still ends after 10 bytes.
REQ-034 Reset asserted after 4 bytes, then a new A5 frame -> no frame_done for the aborted frame, and the new frame delivers 10 bytes correctly.
REQ-035 With BYTE_DEFRAMER_PARITY_EN, byte 8'h03 sent with parity bit 1 -> byte_valid with data_out=8'h03 and parity_err=1; with parity bit 0 -> parity_err=0.

Source files
------------

// File: rtl/deframer_pkg.sv
// deframer_pkg: shared state encoding and default framing constants for byte_deframer.
package deframer_pkg;
    typedef enum logic [1:0] {HUNT, PAYLOAD, DONE} state_t;
    localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
    localparam int FRAME_LEN_DEF = 10;
endpackage

// File: rtl/sync_detector.sv
// sync_detector: 8-bit serial window (oldest bit at bit 7) with a match flag that
// includes the current valid bit, so the FSM can leave HUNT on that same edge.
module sync_detector
    import deframer_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    input  logic bit_valid,
    input  logic bit_in,
    output logic match
);
    logic [7:0] window;
    logic [7:0] next_window;

    assign next_window = {window[6:0], bit_in};
    assign match = en && bit_valid && next_window == SYNC_WORD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) window <= '0;
        else if (clear) window <= '0;
        else if (en && bit_valid) window <= next_window;
    end
endmodule

// File: rtl/byte_deframer.sv
// byte_deframer: hunts SYNC_WORD in a serial MSB-first stream, then delivers FRAME_LEN bytes.
// Define BYTE_DEFRAMER_PARITY_EN to expect an even-parity bit after every payload byte.
module byte_deframer
    import deframer_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] data_out,
    output logic       byte_valid,
    output logic       start_sink,
    output logic       frame_done,
    output logic       sync_lock,
    output logic       parity_err
);
`ifdef BYTE_DEFRAMER_PARITY_EN
    localparam int SW = 8;
    localparam logic [3:0] BIT_LAST = 4'd8;
`else
    localparam int SW = 7;
    localparam logic [3:0] BIT_LAST = 4'd7;
`endif
    localparam logic [7:0] LEN = 8'(FRAME_LEN);

    state_t state;
    logic [SW-1:0] shreg;
    logic [3:0] idx;
    logic [7:0] cnt;
    logic [7:0] byte_now;
    logic match;
    logic perr;

    // Without parity the 8th bit completes the byte directly, so only 7 bits are held.
`ifdef BYTE_DEFRAMER_PARITY_EN
    assign byte_now = shreg;
    assign perr = ^shreg ^ bit_in;
`else
    assign byte_now = {shreg, bit_in};
    assign perr = 1'b0;
`endif

    sync_detector #(.SYNC_WORD(SYNC_WORD)) u_sync (
        .clk(clk),
        .reset(reset),
        .en(state == HUNT),
        .clear(state == DONE),
        .bit_valid(bit_valid),
        .bit_in(bit_in),
        .match(match)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HUNT;
            shreg <= '0;
            idx <= '0;
            cnt <= '0;
            data_out <= '0;
            byte_valid <= 1'b0;
            start_sink <= 1'b0;
            frame_done <= 1'b0;
            sync_lock <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            start_sink <= 1'b0;
            frame_done <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                HUNT: if (match) begin
                    state <= PAYLOAD;
                    start_sink <= 1'b1;
                    sync_lock <= 1'b1;
                end
                PAYLOAD: if (bit_valid) begin
                    shreg <= {shreg[SW-2:0], bit_in};
                    if (idx == BIT_LAST) begin
                        idx <= '0;
                        data_out <= byte_now;
                        byte_valid <= 1'b1;
                        parity_err <= perr;
                        cnt <= cnt + 8'd1;
                        // Leave on the delivering edge so frame_done trails byte_valid by one cycle.
                        if (cnt + 8'd1 == LEN) begin
                            state <= DONE;
                            sync_lock <= 1'b0;
                        end
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    shreg <= '0;
                    idx <= '0;
                    cnt <= '0;
                    state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_deframer.sv
// tb_byte_deframer: random framed streams checked cycle by cycle against expectations
// derived from the framing rules (sync search over the bit list, byte list, pulse positions).
module tb_byte_deframer;
    localparam int FL = 10;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef BYTE_DEFRAMER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic [7:0] data_out;
    logic byte_valid, start_sink, frame_done, sync_lock, parity_err;
    int errors = 0;
    int checks = 0;

    logic sv[$];
    logic sb[$];
    int bv_at[$];
    logic [7:0] eb[$];
    logic ep[$];
    int ss_at;
    logic [7:0] cur_data = 8'h00;
    logic [7:0] pl [FL];
    logic [FL-1:0] flips;

    byte_deframer #(.SYNC_WORD(SYNC), .FRAME_LEN(FL)) dut (
        .clk(clk),
        .reset(reset),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .data_out(data_out),
        .byte_valid(byte_valid),
        .start_sink(start_sink),
        .frame_done(frame_done),
        .sync_lock(sync_lock),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " data_out"}, 32'(data_out), 32'h0);
        check({tag, " byte_valid"}, 32'(byte_valid), 32'h0);
        check({tag, " start_sink"}, 32'(start_sink), 32'h0);
        check({tag, " frame_done"}, 32'(frame_done), 32'h0);
        check({tag, " sync_lock"}, 32'(sync_lock), 32'h0);
        check({tag, " parity_err"}, 32'(parity_err), 32'h0);
    endtask

    // Index in the valid-bit list where SYNC first completes, window starting all-zero.
    function automatic int first_sync(input logic q[$]);
        logic [7:0] w = 8'h00;
        foreach (q[i]) begin
            w = {w[6:0], q[i]};
            if (w == SYNC) return i;
        end
        return -1;
    endfunction

    task automatic push(input logic b, input int gap_mode);
        int g = gap_mode == 1 ? 1 : gap_mode == 2 ? int'($urandom_range(2)) : 0;
        repeat (g) begin
            sv.push_back(1'b0);
            sb.push_back(1'($urandom));
        end
        sv.push_back(1'b1);
        sb.push_back(b);
    endtask

    task automatic build(input int gap_mode);
        logic hb[$];
        sv.delete(); sb.delete(); bv_at.delete(); eb.delete(); ep.delete();
        do begin
            hb.delete();
            repeat ($urandom_range(12, 2)) hb.push_back(1'($urandom));
            for (int i = 7; i >= 0; i--) hb.push_back(SYNC[i]);
        end while (first_sync(hb) != hb.size() - 1);
        foreach (hb[i]) push(hb[i], gap_mode);
        ss_at = sv.size();
        for (int k = 0; k < FL; k++) begin
            for (int i = 7; i >= 0; i--) push(pl[k][i], gap_mode);
            ep.push_back(PAR & flips[k]);
            if (PAR) push(^pl[k] ^ flips[k], gap_mode);
            bv_at.push_back(sv.size());
            eb.push_back(pl[k]);
        end
        // Zero bits after the frame: the first falls in the discard cycle, the rest are harmless hunt input.
        repeat (6) begin
            sv.push_back(1'b1);
            sb.push_back(1'b0);
        end
    endtask

    // Sample s reflects the inputs driven for drive s-1.
    task automatic play(input int n);
        int b = 0;
        logic [7:0] d = cur_data;
        int last = bv_at[FL-1];
        for (int s = 0; s <= n; s++) begin
            logic bv = b < bv_at.size() && bv_at[b] == s;
            logic pe = 1'b0;
            if (bv) begin
                d = eb[b];
                pe = ep[b];
                b++;
            end
            @(negedge clk);
            check("byte_valid", 32'(byte_valid), 32'(bv));
            check("data_out", 32'(data_out), 32'(d));
            check("parity_err", 32'(parity_err), 32'(pe));
            check("start_sink", 32'(start_sink), 32'(s == ss_at));
            check("frame_done", 32'(frame_done), 32'(s == last + 1));
            check("sync_lock", 32'(sync_lock), 32'(s >= ss_at && s < last));
            if (s < n) begin
                bit_valid = sv[s];
                bit_in = sb[s];
            end else begin
                bit_valid = 1'b0;
            end
        end
        cur_data = d;
    endtask

    task automatic rand_payload();
        foreach (pl[k]) pl[k] = 8'($urandom);
        flips = FL'($urandom);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle("in reset");
        reset = 1'b1;
        @(negedge clk);
        check_idle("after reset");

        foreach (pl[k]) pl[k] = 8'(k);
        flips = '0;
        build(0);
        play(sv.size());

        build(1);
        play(sv.size());

        rand_payload();
        pl[4] = SYNC;
        pl[5] = SYNC;
        build(2);
        play(sv.size());

        rand_payload();
        build(0);
        play(bv_at[3] + 5);
        reset = 1'b0;
        #1;
        check_idle("async reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cur_data = 8'h00;
        rand_payload();
        build(2);
        play(sv.size());

        if (PAR) begin
            rand_payload();
            pl[2] = 8'h03;
            pl[3] = 8'h03;
            flips = '0;
            flips[2] = 1'b1;
            build(0);
            play(sv.size());
        end

        for (int t = 0; t < 6; t++) begin
            rand_payload();
            build(int'($urandom_range(2)));
            play(sv.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
